// File: rtl/ddr_req_arbiter.sv
// Round-robin arbiter sharing one DDR command port among NREQ requesters; one burst per grant.
// Optional watchdog: define DDR_ARB_WATCHDOG_EN to abort stalled transactions after TMO_CYCLES.
module ddr_req_arbiter #(
  parameter int NREQ       = 4,
  parameter int ABITS      = 30,
  parameter int LBITS      = 8,
  parameter int TMO_CYCLES = 1024
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic                    i_calib_done,
  input  logic [NREQ-1:0]         i_req_valid,
  input  logic [NREQ*ABITS-1:0]   i_req_addr,
  input  logic [NREQ-1:0]         i_req_write,
  input  logic [NREQ*LBITS-1:0]   i_req_len,
  output logic [NREQ-1:0]         o_req_ready,
  output logic [NREQ-1:0]         o_done,
  output logic                    o_err,
  output logic                    o_mem_valid,
  output logic [ABITS-1:0]        o_mem_addr,
  output logic                    o_mem_write,
  output logic [LBITS-1:0]        o_mem_len,
  input  logic                    i_mem_ready,
  input  logic                    i_mem_beat,
  input  logic                    i_mem_resp,
  output logic [$clog2(NREQ)-1:0] o_grant_id,
  output logic                    o_busy
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = LBITS + 1;

  localparam logic [1:0] S_WAIT_CALIB = 2'd0;
  localparam logic [1:0] S_IDLE       = 2'd1;
  localparam logic [1:0] S_ISSUE      = 2'd2;
  localparam logic [1:0] S_XFER       = 2'd3;

  logic [1:0]    state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] win;
  logic [GW:0]   idx;
  logic          found;
  logic          grant;
  logic          busy;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          extra_beat;
  logic          len_err;
  logic          fin;
  logic          tmo;

  logic [ABITS-1:0] addr_a [NREQ];
  logic [LBITS-1:0] len_a  [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign addr_a[k] = i_req_addr[k*ABITS +: ABITS];
    assign len_a[k]  = i_req_len[k*LBITS +: LBITS];
  end

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_ptr} + (GW+1)'(i);
      if (idx >= (GW+1)'(NREQ)) idx = idx - (GW+1)'(NREQ);
      if (!found && i_req_valid[idx[GW-1:0]]) begin
        found = 1'b1;
        win   = idx[GW-1:0];
      end
    end
  end

  assign grant      = (state == S_IDLE) && i_calib_done && found;
  assign busy       = (state == S_ISSUE) || (state == S_XFER);
  assign extra_beat = busy && i_mem_beat && (cnt == '0);
  assign cnt_nxt    = (busy && i_mem_beat && (cnt != '0)) ? cnt - CW'(1) : cnt;

`ifdef DDR_ARB_WATCHDOG_EN
  logic [15:0] wd;
  logic        activity;
  assign activity = i_mem_ready || i_mem_beat || i_mem_resp;
  assign tmo      = busy && !activity && (wd == 16'(TMO_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_nrst)     wd <= '0;
    else if (grant)  wd <= '0;
    else if (busy)   wd <= activity ? 16'd0 : wd + 16'd1;
  end
`else
  assign tmo = 1'b0;
`endif

  assign fin         = ((state == S_XFER) && i_mem_resp) || tmo;
  assign o_req_ready = grant ? (NREQ'(1) << win) : '0;
  assign o_done      = (fin && i_nrst) ? (NREQ'(1) << o_grant_id) : '0;
  // Beat in the completing cycle is already folded into cnt_nxt/extra_beat.
  assign o_err       = fin && i_nrst && (tmo || len_err || extra_beat || (cnt_nxt != '0));
  assign o_mem_valid = (state == S_ISSUE) && !tmo;
  assign o_busy      = busy;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state       <= S_WAIT_CALIB;
      rr_ptr      <= '0;
      cnt         <= '0;
      len_err     <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_write <= 1'b0;
      o_mem_len   <= '0;
      o_grant_id  <= '0;
    end else begin
      case (state)
        S_WAIT_CALIB: if (i_calib_done) state <= S_IDLE;
        S_IDLE: begin
          if (!i_calib_done) begin
            state <= S_WAIT_CALIB;
          end else if (found) begin
            o_mem_addr  <= addr_a[win];
            o_mem_write <= i_req_write[win];
            o_mem_len   <= len_a[win];
            o_grant_id  <= win;
            cnt         <= {1'b0, len_a[win]} + CW'(1);
            len_err     <= 1'b0;
            rr_ptr      <= (win == GW'(NREQ - 1)) ? '0 : win + GW'(1);
            state       <= S_ISSUE;
          end
        end
        default: begin
          cnt <= cnt_nxt;
          if (extra_beat) len_err <= 1'b1;
          if (fin)                                 state <= S_IDLE;
          else if (state == S_ISSUE && i_mem_ready) state <= S_XFER;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Directed self-checking bench for ddr_req_arbiter (NREQ=4); watchdog scenario built only with DDR_ARB_WATCHDOG_EN.
module tb_ddr_req_arbiter;
  localparam int NREQ  = 4;
  localparam int ABITS = 30;
  localparam int LBITS = 8;
`ifdef DDR_ARB_WATCHDOG_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic                  clk = 1'b0;
  logic                  nrst;
  logic                  calib;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*ABITS-1:0] req_addr;
  logic [NREQ-1:0]       req_write;
  logic [NREQ*LBITS-1:0] req_len;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       done;
  logic                  err;
  logic                  mem_valid;
  logic [ABITS-1:0]      mem_addr;
  logic                  mem_write;
  logic [LBITS-1:0]      mem_len;
  logic                  mem_ready;
  logic                  mem_beat;
  logic                  mem_resp;
  logic [1:0]            grant_id;
  logic                  busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ddr_req_arbiter #(.NREQ(NREQ), .ABITS(ABITS), .LBITS(LBITS), .TMO_CYCLES(TMO)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_calib_done(calib),
    .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_write(req_write), .i_req_len(req_len),
    .o_req_ready(req_ready), .o_done(done), .o_err(err),
    .o_mem_valid(mem_valid), .o_mem_addr(mem_addr), .o_mem_write(mem_write), .o_mem_len(mem_len),
    .i_mem_ready(mem_ready), .i_mem_beat(mem_beat), .i_mem_resp(mem_resp),
    .o_grant_id(grant_id), .o_busy(busy)
  );

  function automatic logic [ABITS-1:0] addr_of(input int k);
    return ABITS'(32'h0100_0000 + 32'h40 * (k + 1));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset, then leave the DUT in IDLE with calibration high.
  task automatic do_reset;
    nrst = 1'b0; calib = 1'b1;
    mem_ready = 1'b0; mem_beat = 1'b0; mem_resp = 1'b0;
    tick;
    nrst = 1'b1;
    tick;
  endtask

  // Entered in the ISSUE cycle; returns the completion observed on the last beat.
  task automatic do_xfer(input int nbeats, output logic [NREQ-1:0] d, output logic e);
    d = '0; e = 1'b0;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    for (int b = 1; b <= nbeats; b++) begin
      mem_beat = 1'b1;
      mem_resp = (b == nbeats);
      #1;
      if (b == nbeats) begin d = done; e = err; end
      tick;
    end
    mem_beat = 1'b0; mem_resp = 1'b0;
  endtask

  task automatic test_reset;
    nrst = 1'b0; calib = 1'b0; req_valid = '0; req_write = '0;
    mem_ready = 1'b0; mem_beat = 1'b0; mem_resp = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      req_addr[k*ABITS +: ABITS] = addr_of(k);
      req_len[k*LBITS +: LBITS]  = '0;
    end
    tick; tick;
    nrst = 1'b1;
    #1;
    checks++; if (mem_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%b want=0", mem_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id got=%0d want=0", grant_id); end
    checks++; if (done !== '0 || err !== 1'b0) begin failures++; $display("FAIL reset_done got=%b/%b want=0000/0", done, err); end
  endtask

  task automatic test_calib_gate;
    logic [NREQ-1:0] d; logic e;
    calib = 1'b0;
    req_valid = 4'b0001;
    req_len[0 +: LBITS] = 8'd3;
    for (int c = 0; c < 20; c++) begin
      tick;
      checks++; if (req_ready !== '0) begin failures++; $display("FAIL calib_gate_ready cyc=%0d got=%b want=0000", c, req_ready); end
    end
    calib = 1'b1;
    tick;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL calib_release_ready got=%b want=0001", req_ready); end
    tick;
    req_valid = '0;
    #1;
    checks++; if (mem_valid !== 1'b1 || mem_addr !== addr_of(0)) begin failures++; $display("FAIL calib_cmd got=%b/%h want=1/%h", mem_valid, mem_addr, addr_of(0)); end
    do_xfer(4, d, e);
    checks++; if (d !== 4'b0001 || e !== 1'b0) begin failures++; $display("FAIL calib_done got=%b/%b want=0001/0", d, e); end
  endtask

  task automatic test_round_robin;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0] d; logic e;
    do_reset;
    req_len = '0;
    req_valid = 4'b1111;
    foreach (order[n]) begin
      #1;
      checks++; if (req_ready !== (4'b0001 << order[n])) begin failures++; $display("FAIL rr_ready n=%0d got=%b want=%b", n, req_ready, 4'b0001 << order[n]); end
      tick;
      checks++; if (grant_id !== 2'(order[n]) || req_ready !== '0) begin failures++; $display("FAIL rr_grant n=%0d got=%0d/%b want=%0d/0000", n, grant_id, req_ready, order[n]); end
      do_xfer(1, d, e);
      checks++; if (d !== (4'b0001 << order[n]) || e !== 1'b0) begin failures++; $display("FAIL rr_done n=%0d got=%b/%b want=%b/0", n, d, e, 4'b0001 << order[n]); end
    end
    req_valid = '0;
  endtask

  task automatic test_burst_count;
    int nb [3]   = '{8, 7, 9};
    logic exp_e [3] = '{1'b0, 1'b1, 1'b1};
    logic [NREQ-1:0] d; logic e;
    do_reset;
    req_write = 4'b0100;
    req_len[2*LBITS +: LBITS] = 8'd7;
    foreach (nb[n]) begin
      req_valid = 4'b0100;
      tick;
      req_valid = '0;
      #1;
      checks++; if (grant_id !== 2'd2 || mem_write !== 1'b1 || mem_len !== 8'd7) begin failures++; $display("FAIL burst_cmd n=%0d got=%0d/%b/%0d want=2/1/7", n, grant_id, mem_write, mem_len); end
      do_xfer(nb[n], d, e);
      checks++; if (d !== 4'b0100 || e !== exp_e[n]) begin failures++; $display("FAIL burst_done beats=%0d got=%b/%b want=0100/%b", nb[n], d, e, exp_e[n]); end
    end
    req_write = '0;
    req_len = '0;
  endtask

  task automatic test_backpressure;
    logic [NREQ-1:0] d; logic e;
    do_reset;
    req_len[1*LBITS +: LBITS] = 8'd5;
    req_valid = 4'b1110;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_ready got=%b want=0010", req_ready); end
    tick;
    req_valid = 4'b1100;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== addr_of(1) || mem_len !== 8'd5 || req_ready !== '0) begin
        failures++;
        $display("FAIL bp_stable cyc=%0d got=%b/%h/%0d/%b want=1/%h/5/0000", c, mem_valid, mem_addr, mem_len, req_ready, addr_of(1));
      end
      tick;
    end
    do_xfer(6, d, e);
    checks++; if (d !== 4'b0010 || e !== 1'b0) begin failures++; $display("FAIL bp_done got=%b/%b want=0010/0", d, e); end
    req_valid = '0;
    req_len = '0;
  endtask

  task automatic test_mid_reset;
    do_reset;
    req_len[3*LBITS +: LBITS] = 8'd3;
    req_valid = 4'b1000;
    tick;
    req_valid = '0;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0; mem_beat = 1'b1;
    tick;
    mem_beat = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
    nrst = 1'b0;
    tick;
    nrst = 1'b1;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || busy !== 1'b0 || done !== '0 || mem_addr !== '0 || grant_id !== 2'd0 || mem_len !== '0) begin
      failures++;
      $display("FAIL midrst_outputs got=%b/%b/%b/%h/%0d/%0d want=0/0/0000/0/0/0", mem_valid, busy, done, mem_addr, grant_id, mem_len);
    end
    mem_resp = 1'b1;
    #1;
    checks++; if (done !== '0) begin failures++; $display("FAIL midrst_no_done got=%b want=0000", done); end
    tick;
    mem_resp = 1'b0;
    req_len = '0;
  endtask

`ifdef DDR_ARB_WATCHDOG_EN
  task automatic test_watchdog;
    do_reset;
    req_valid = 4'b0001;
    tick;
    req_valid = '0;
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    for (int c = 1; c < TMO; c++) begin
      #1;
      checks++; if (done !== '0) begin failures++; $display("FAIL wd_early cyc=%0d got=%b want=0000", c, done); end
      tick;
    end
    #1;
    checks++; if (done !== 4'b0001 || err !== 1'b1) begin failures++; $display("FAIL wd_timeout got=%b/%b want=0001/1", done, err); end
    tick;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL wd_next_grant got=%b want=0010", req_ready); end
    tick;
    req_valid = '0;
  endtask
`endif

  initial begin
    test_reset;
    test_calib_gate;
    test_round_robin;
    test_burst_count;
    test_backpressure;
    test_mid_reset;
`ifdef DDR_ARB_WATCHDOG_EN
    test_watchdog;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
